// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding
// and the helper that sizes the iteration counter for a given operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // Counter must be able to hold WIDTH itself, hence the +1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_cond_neg.sv
// Conditional two's-complement negate: result = negate ? -value : value.
// Used for operand magnitudes and for the final sign fix-up of the product.
module mult_cond_neg #(
    parameter int W = 32
) (
    input  logic         negate,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_seq_param.sv
// Iterative shift-add multiplier, one multiplier bit per clock, with per-operation
// signed/unsigned mode and valid/ready handshakes on both input and output.
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 sign_mode;
    logic                 sign_diff;

    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH-1:0]   acc_fixed;
    logic [WIDTH:0]       partial;
    logic [2*WIDTH-1:0]   acc_step;

    // Magnitudes are taken only in signed mode; the most negative value maps to 2^(W-1).
    mult_cond_neg #(.W(WIDTH)) u_abs_a (
        .negate (is_signed & multiplicand[WIDTH-1]),
        .value  (multiplicand),
        .result (a_abs)
    );

    mult_cond_neg #(.W(WIDTH)) u_abs_b (
        .negate (is_signed & multiplier[WIDTH-1]),
        .value  (multiplier),
        .result (b_abs)
    );

    mult_cond_neg #(.W(2*WIDTH)) u_fix (
        .negate (sign_mode & sign_diff),
        .value  (acc),
        .result (acc_fixed)
    );

    // Upper half accumulates with a carry bit that is shifted back in, so nothing is lost.
    always_comb begin
        partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step = {partial, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            sign_mode <= 1'b0;
            sign_diff <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_mode <= is_signed;
                        sign_diff <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                        mcand     <= a_abs;
                        acc       <= {{WIDTH{1'b0}}, b_abs};
                        count     <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    product   <= acc_fixed;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
